// File: rtl/lzrw_pkg.sv
// Shared LZRW1 packer types: default field widths, token layout and packer states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lzrw_pkg;

    localparam int LZRW_GROUP_ITEMS = 16;
    localparam int LZRW_LEN_W       = 4;
    localparam int LZRW_OFF_W       = 12;

    typedef struct packed {
        logic                  is_copy;
        logic [LZRW_LEN_W-1:0] length;
        logic [LZRW_OFF_W-1:0] offset;
        logic [7:0]            literal;
    } token_t;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        CTRL_LO = 3'd1,
        CTRL_HI = 3'd2,
        DATA    = 3'd3,
        DONE    = 3'd4
    } pack_state_t;

endpackage

// File: rtl/lzrw_group_buf.sv
// Group byte buffer: appends one or two bytes per token, replays them in order.
// Latency: appended bytes are readable the cycle after the write.
// Backpressure: none internally; the owner advances the read pointer on handshake.
module lzrw_group_buf #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic             wr_two,
    input  logic [7:0]       wr_b0,
    input  logic [7:0]       wr_b1,
    input  logic             rd_adv,
    input  logic             peek_next,
    output logic [7:0]       rd_data,
    output logic [PTR_W-1:0] nbytes,
    output logic [PTR_W-1:0] rd_ptr
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [AW-1:0]    wr_idx0;
    logic [AW-1:0]    wr_idx1;
    logic [AW-1:0]    rd_idx;

    assign wr_idx0 = wr_ptr[AW-1:0];
    assign wr_idx1 = AW'(wr_ptr + PTR_W'(1));
    // peek_next looks one byte ahead so the registered output can be preloaded;
    // past the end the index wraps harmlessly since that value is never used
    assign rd_idx  = peek_next ? AW'(rd_ptr + PTR_W'(1)) : AW'(rd_ptr);
    assign rd_data = mem[rd_idx];
    assign nbytes  = wr_ptr;

    // write and read pointers; clear starts a fresh group
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (wr_two ? PTR_W'(2) : PTR_W'(1));
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // byte storage; contents are only meaningful below wr_ptr
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx0] <= wr_b0;
            if (wr_two) begin
                mem[wr_idx1] <= wr_b1;
            end
        end
    end

endmodule

// File: rtl/lzrw_group_packer.sv
// LZRW1 group packer: groups tokens, emits control word (lo, hi) then item bytes.
// Latency: first output byte is valid the cycle after the closing token handshake.
// Backpressure: out_ready=0 holds the current byte; in_ready is low outside COLLECT.
module lzrw_group_packer
    import lzrw_pkg::*;
#(
    parameter int GROUP_ITEMS = LZRW_GROUP_ITEMS,
    parameter int LEN_W       = LZRW_LEN_W,
    parameter int OFF_W       = LZRW_OFF_W,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_copy,
    input  logic [LEN_W-1:0] in_length,
    input  logic [OFF_W-1:0] in_offset,
    input  logic [7:0]       in_literal,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             done,
    output logic [CNT_W-1:0] tokens_total,
    output logic [CNT_W-1:0] bytes_total
);
    localparam int DEPTH = 2 * GROUP_ITEMS;
    localparam int PTR_W = $clog2(DEPTH) + 1;

    if (LEN_W + OFF_W != 16) begin : g_bad_fields
        $error("lzrw_group_packer: LEN_W + OFF_W must equal 16");
    end
    if (GROUP_ITEMS < 1 || GROUP_ITEMS > 16) begin : g_bad_group
        $error("lzrw_group_packer: GROUP_ITEMS must be 1..16");
    end

    pack_state_t      state, state_nxt;
    logic [15:0]      ctrl, ctrl_nxt;
    logic [4:0]       item_cnt;
    logic             last_flag;
    logic             acc, close, out_fire;
    logic [15:0]      copy_word;
    logic [7:0]       gb_wr_b0, gb_rd_data;
    logic             gb_rd_adv, gb_peek, grp_clear;
    logic [PTR_W-1:0] gb_nbytes, gb_rd_ptr;
    logic             rd_last;
    logic             out_valid_d, out_last_d;
    logic [7:0]       out_data_d;

    assign acc       = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign close     = acc && (in_last || item_cnt == 5'(GROUP_ITEMS - 1));
    assign ctrl_nxt  = ctrl | (16'(in_is_copy) << item_cnt);
    // with LEN_W+OFF_W fixed at 16 a copy is exactly this word, high byte first
    assign copy_word = {in_length, in_offset};
    assign gb_wr_b0  = in_is_copy ? copy_word[15:8] : in_literal;
    assign rd_last   = (gb_rd_ptr == gb_nbytes - PTR_W'(1));

    lzrw_group_buf #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_gbuf (
        .clock    (clock),
        .reset    (reset),
        .clear    (grp_clear),
        .wr_en    (acc),
        .wr_two   (in_is_copy),
        .wr_b0    (gb_wr_b0),
        .wr_b1    (copy_word[7:0]),
        .rd_adv   (gb_rd_adv),
        .peek_next(gb_peek),
        .rd_data  (gb_rd_data),
        .nbytes   (gb_nbytes),
        .rd_ptr   (gb_rd_ptr)
    );

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= COLLECT;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (close)    state_nxt = CTRL_LO;
            CTRL_LO: if (out_fire) state_nxt = CTRL_HI;
            CTRL_HI: if (out_fire) state_nxt = DATA;
            DATA:    if (out_fire && rd_last) state_nxt = last_flag ? DONE : COLLECT;
            DONE:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // buffer control and the next value of the registered output byte
    always_comb begin
        gb_rd_adv   = 1'b0;
        gb_peek     = 1'b0;
        grp_clear   = 1'b0;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        case (state)
            COLLECT: begin
                if (close) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ctrl_nxt[7:0];
                end
            end
            CTRL_LO: begin
                if (out_fire) out_data_d = ctrl[15:8];
            end
            CTRL_HI: begin
                if (out_fire) begin
                    out_data_d = gb_rd_data;
                    out_last_d = last_flag && (gb_nbytes == PTR_W'(1));
                end
            end
            DATA: begin
                gb_peek = 1'b1;
                if (out_fire) begin
                    gb_rd_adv = 1'b1;
                    if (rd_last) begin
                        grp_clear   = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = 8'h00;
                    end else begin
                        out_data_d = gb_rd_data;
                        out_last_d = last_flag && (gb_rd_ptr + PTR_W'(2) == gb_nbytes);
                    end
                end
            end
            default: ;
        endcase
    end

    // per-group control word, token count and end-of-stream flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl      <= '0;
            item_cnt  <= '0;
            last_flag <= 1'b0;
        end else if (grp_clear) begin
            ctrl      <= '0;
            item_cnt  <= '0;
            last_flag <= 1'b0;
        end else if (acc) begin
            ctrl     <= ctrl_nxt;
            item_cnt <= item_cnt + 5'd1;
            if (close) last_flag <= in_last;
        end
    end

    // registered handshake outputs and the done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            in_ready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            in_ready  <= (state_nxt == COLLECT);
            done      <= (state_nxt == DONE);
        end
    end

    // free-running statistics, wrapping at 2^CNT_W
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tokens_total <= '0;
            bytes_total  <= '0;
        end else begin
            if (acc)      tokens_total <= tokens_total + CNT_W'(1);
            if (out_fire) bytes_total  <= bytes_total + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lzrw_group_packer.sv
// Directed bench for lzrw_group_packer (16-item and 8-item instances).
// Latency: checks first byte the cycle after the closing token.
// Backpressure: exercises out_ready stalls and in_ready gating.
module tb_lzrw_group_packer;
    import lzrw_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid, in_is_copy, in_last, out_ready;
    logic [3:0]  in_length;
    logic [11:0] in_offset;
    logic [7:0]  in_literal;
    logic        sel8, rnd;

    logic        a_in_ready, a_out_valid, a_out_last, a_done;
    logic [7:0]  a_out_data;
    logic [31:0] a_tokens, a_bytes;
    logic        b_in_ready, b_out_valid, b_out_last, b_done;
    logic [7:0]  b_out_data;
    logic [31:0] b_tokens, b_bytes;

    logic        mon_valid, mon_last, mon_done, mon_in_ready;
    logic [7:0]  mon_data;
    logic [31:0] mon_tokens, mon_bytes;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    logic [7:0]  got_b[$], exp_b[$];
    logic        got_l[$], exp_l[$];

    lzrw_group_packer #(.GROUP_ITEMS(16), .LEN_W(4), .OFF_W(12), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid & ~sel8), .in_ready(a_in_ready),
        .in_is_copy(in_is_copy), .in_length(in_length), .in_offset(in_offset),
        .in_literal(in_literal), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .done(a_done),
        .tokens_total(a_tokens), .bytes_total(a_bytes)
    );

    lzrw_group_packer #(.GROUP_ITEMS(8), .LEN_W(4), .OFF_W(12), .CNT_W(32)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid & sel8), .in_ready(b_in_ready),
        .in_is_copy(in_is_copy), .in_length(in_length), .in_offset(in_offset),
        .in_literal(in_literal), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .done(b_done),
        .tokens_total(b_tokens), .bytes_total(b_bytes)
    );

    assign mon_valid    = sel8 ? b_out_valid : a_out_valid;
    assign mon_data     = sel8 ? b_out_data  : a_out_data;
    assign mon_last     = sel8 ? b_out_last  : a_out_last;
    assign mon_done     = sel8 ? b_done      : a_done;
    assign mon_in_ready = sel8 ? b_in_ready  : a_in_ready;
    assign mon_tokens   = sel8 ? b_tokens    : a_tokens;
    assign mon_bytes    = sel8 ? b_bytes     : a_bytes;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send(input logic c, input logic [3:0] len, input logic [11:0] off,
                        input logic [7:0] lit, input logic last);
        int w;
        w = 0;
        in_valid = 1'b1; in_is_copy = c; in_length = len; in_offset = off;
        in_literal = lit; in_last = last;
        while (!mon_in_ready && w < 300) begin
            tick();
            w++;
        end
        check("send_wait", 32'(w < 300), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int w;
        w = 0;
        while (got_b.size() < n && w < 2000) begin
            tick();
            w++;
        end
        check("drain_count", got_b.size(), n);
    endtask

    task automatic push(input logic [7:0] b, input logic l);
        exp_b.push_back(b);
        exp_l.push_back(l);
    endtask

    task automatic clear_q();
        got_b.delete(); got_l.delete(); exp_b.delete(); exp_l.delete();
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
            check($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
        end
    endtask

    // alternating literal/copy stream of 20 tokens; copy k = len k, offset 0x123+k
    task automatic send_alt();
        for (int k = 0; k < 20; k++) begin
            send(k[0], 4'(k), 12'(12'h123 + k), 8'(8'h10 + k), k == 19);
        end
    endtask

    task automatic exp_alt();
        push(8'hAA, 1'b0); push(8'hAA, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 16) begin
                push(8'h0A, 1'b0); push(8'h00, 1'b0);
            end
            if (k[0]) begin
                push({4'(k), 4'h1}, 1'b0);
                push(8'(8'h23 + k), k == 19);
            end else begin
                push(8'(8'h10 + k), 1'b0);
            end
        end
    endtask

    // output capture, emit-state invariants and stall stability (sampled mid-cycle)
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clock);
            if (mon_valid && out_ready) begin
                got_b.push_back(mon_data);
                got_l.push_back(mon_last);
            end
            if (mon_done) done_cnt++;
            if (mon_valid) check("in_ready_while_emit", 32'(mon_in_ready), 32'd0);
            if (prev_stall && mon_valid) check("stall_data_hold", 32'(mon_data), 32'(prev_data));
            prev_stall = mon_valid && !out_ready;
            prev_data  = mon_data;
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_is_copy = 1'b0; in_last = 1'b0;
        in_length = 4'h0; in_offset = 12'h000; in_literal = 8'h00;
        out_ready = 1'b1; sel8 = 1'b0; rnd = 1'b0;

        // reset state
        #12;
        check("rst_out_valid", 32'(mon_valid), 32'd0);
        check("rst_in_ready",  32'(mon_in_ready), 32'd0);
        check("rst_out_data",  32'(mon_data), 32'd0);
        check("rst_out_last",  32'(mon_last), 32'd0);
        check("rst_done",      32'(mon_done), 32'd0);
        check("rst_tokens",    mon_tokens, 32'd0);
        check("rst_bytes",     mon_bytes, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("in_ready_after_release", 32'(mon_in_ready), 32'd1);

        // 1: sixteen literals, one full group
        clear_q();
        for (int i = 0; i < 16; i++) send(1'b0, 4'h0, 12'h000, 8'(8'h41 + i), i == 15);
        check("s1_latency_valid", 32'(mon_valid), 32'd1);
        check("s1_first_byte",    32'(mon_data), 32'h00);
        push(8'h00, 1'b0); push(8'h00, 1'b0);
        for (int i = 0; i < 16; i++) push(8'(8'h41 + i), i == 15);
        drain(18);
        tick(); tick();
        cmp_stream("s1");
        check("s1_done_cnt", done_cnt, 1);
        check("s1_tokens", mon_tokens, 32'd16);
        check("s1_bytes",  mon_bytes, 32'd18);
        check("s1_in_ready_back", 32'(mon_in_ready), 32'd1);

        // 2: single copy token with last
        clear_q();
        send(1'b1, 4'h3, 12'hABC, 8'h00, 1'b1);
        check("s2_latency_valid", 32'(mon_valid), 32'd1);
        check("s2_in_ready_low",  32'(mon_in_ready), 32'd0);
        push(8'h01, 1'b0); push(8'h00, 1'b0); push(8'h3A, 1'b0); push(8'hBC, 1'b1);
        drain(4);
        tick(); tick();
        cmp_stream("s2");
        check("s2_done_cnt", done_cnt, 2);
        check("s2_bytes", mon_bytes, 32'd22);

        // 3: alternating literal/copy, two groups
        clear_q();
        send_alt();
        exp_alt();
        drain(34);
        tick(); tick();
        cmp_stream("s3");
        check("s3_done_cnt", done_cnt, 3);
        check("s3_tokens", mon_tokens, 32'd37);
        check("s3_bytes",  mon_bytes, 32'd56);

        // 4: same stream under random output backpressure
        clear_q();
        rnd = 1'b1;
        send_alt();
        exp_alt();
        drain(34);
        rnd = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        cmp_stream("s4");
        check("s4_done_cnt", done_cnt, 4);
        check("s4_tokens", mon_tokens, 32'd57);
        check("s4_bytes",  mon_bytes, 32'd90);

        // 5: reset with five data bytes still to go
        clear_q();
        for (int i = 0; i < 10; i++) send(1'b0, 4'h0, 12'h000, 8'(8'h70 + i), i == 9);
        drain(7);
        #2;
        reset = 1'b0;
        #1;
        check("s5_async_out_valid", 32'(mon_valid), 32'd0);
        check("s5_in_ready", 32'(mon_in_ready), 32'd0);
        check("s5_tokens",   mon_tokens, 32'd0);
        check("s5_bytes",    mon_bytes, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        clear_q();
        send(1'b0, 4'h0, 12'h000, 8'h55, 1'b1);
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h55, 1'b1);
        drain(3);
        tick(); tick();
        cmp_stream("s5");
        check("s5_done_cnt", done_cnt, 5);
        check("s5_tokens_after", mon_tokens, 32'd1);
        check("s5_bytes_after",  mon_bytes, 32'd3);

        // 6: eight-item instance, nine literals
        sel8 = 1'b1;
        tick();
        clear_q();
        for (int i = 0; i < 9; i++) send(1'b0, 4'h0, 12'h000, 8'(8'h61 + i), i == 8);
        push(8'h00, 1'b0); push(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) push(8'(8'h61 + i), 1'b0);
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h69, 1'b1);
        drain(13);
        tick(); tick();
        cmp_stream("s6");
        check("s6_done_cnt", done_cnt, 6);
        check("s6_tokens", mon_tokens, 32'd9);
        check("s6_bytes",  mon_bytes, 32'd13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lzrw_group_packer.md
Name: lzrw_group_packer

Overview:
- Streaming successor to the flat compressed-value array. Accepts LZRW1 tokens (literal or copy) over a valid/ready handshake.
- Groups tokens GROUP_ITEMS at a time and builds the per-group control word.
- Emits the LZRW1 byte stream (control word, then item bytes) over a second valid/ready handshake.
- Sits between the match comparator/hash-table stage and the output memory/DMA writer.

Parameters:
GROUP_ITEMS, 16, tokens per group; control word width; legal range 1..16.
LEN_W, 4, copy length field width.
OFF_W, 12, copy offset width; LEN_W+OFF_W must equal 16 (elaboration-time assertion).
CNT_W, 32, width of the byte/token statistics counters.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  token present.
in_ready  out  1  packer can accept a token.
in_is_copy  in  1  1 = copy token, 0 = literal.
in_length  in  LEN_W  copy length code, passed through unchanged.
in_offset  in  OFF_W  copy offset.
in_literal  in  8  literal byte.
in_last  in  1  final token of the stream.
out_valid  out  1  output byte present.
out_ready  in  1  downstream accepts the byte.
out_data  out  8  output byte.
out_last  out  1  marks the final byte of the stream.
done  out  1  one-cycle pulse after the final byte handshake.
tokens_total  out  CNT_W  tokens accepted since reset.
bytes_total  out  CNT_W  bytes emitted since reset.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - State COLLECT, item/byte counters 0, control register 0.
  - in_ready is 0 while reset is asserted and 1 from the first clock after release.
- Handshakes: a transfer occurs on a clock edge where valid&&ready. Source holds data while valid&&!ready. out_data/out_valid/out_last are registered.
- Token encoding into the group byte buffer (depth 2*GROUP_ITEMS):
  - Literal: one byte, in_literal; control bit 0.
  - Copy: two bytes, {in_length, in_offset[OFF_W-1:8]} then in_offset[7:0]; control bit 1.
  - Token k of the group (k = 0 first) sets ctrl[k]. Unused high bits stay 0.
- FSM:
  - COLLECT: in_ready=1. Each accepted token is appended and the item count increments. When the GROUPth token or an in_last token is accepted, go to CTRL_LO and latch last_flag=in_last. in_ready drops the cycle after that acceptance.
  - CTRL_LO: out_valid=1, out_data=ctrl[7:0]. On handshake go to CTRL_HI.
  - CTRL_HI: out_data=ctrl[15:8], emitted even when GROUP_ITEMS<=8 (upper bits 0). On handshake go to DATA.
  - DATA: emit buffer bytes 0..nbytes-1 in order. On the final byte's handshake:
    - If last_flag: go to DONE.
    - Otherwise clear ctrl, counts and pointers and go to COLLECT.
  - DONE: done=1 for exactly one cycle, then go to COLLECT with all group state cleared. tokens_total/bytes_total are held, never cleared except by reset.
- Latency: the first output byte (out_valid=1) appears in the cycle after the closing token handshake.
- out_last=1 only on the final data byte of a last_flag group.
- Backpressure: out_ready=0 stalls in any emit state with out_data stable. in_ready=0 in all states other than COLLECT.
- Boundaries:
  - A group of all copies fills the buffer exactly (2*GROUP_ITEMS bytes); no overflow is possible.
  - in_last on the first token of a group gives a one-token group: 2 control bytes plus 1 or 2 data bytes.
  - in_valid while in_ready=0 is ignored and the token is not consumed.
  - Reset mid-group or mid-emit discards all buffered data immediately.
  - bytes_total counts control bytes and wraps modulo 2^CNT_W. tokens_total also wraps.

Decomposition:
- Package lzrw_pkg:
  - Constants LZRW_GROUP_ITEMS=16, LZRW_LEN_W=4, LZRW_OFF_W=12.
  - Token struct (is_copy, length, offset, literal).
  - Packer state enum {COLLECT, CTRL_LO, CTRL_HI, DATA, DONE}.
- One natural sub-module: lzrw_group_buf, the byte buffer with write pointer, one-or-two-byte append and read pointer. The FSM and counters live in the top.

Test Plan:
1. 16 literals 0x41..0x50, in_last on the 16th, out_ready=1 -> bytes 0x00,0x00,0x41..0x50; out_last on 0x50; done pulse; bytes_total=18, tokens_total=16.
2. One copy (length=0x3, offset=0xABC) with in_last -> 0x01,0x00,0x3A,0xBC; out_last on 0xBC.
3. Tokens alternating literal/copy, 20 total, in_last on the 20th -> first control word 0xAAAA with 24 data bytes; second group of 4 tokens, control word 0x000A; in_ready low throughout the first emit.
4. out_ready toggled randomly 50% during scenario 3 -> byte sequence identical; out_data stable while stalled.
5. Reset asserted mid-DATA of a group with 5 bytes left -> out_valid=0 asynchronously; new stream after release starts with a fresh control word; counters 0.
6. GROUP_ITEMS=8 instance, 9 literals with in_last on the 9th -> control bytes 0x00,0x00 per group; two groups of 8 and 1 literals.
